// File: rtl/sine_sample_pwm.sv
// sine_sample_pwm
// Steps a phase accumulator on each rising edge of the (asynchronous) divided
// tick, converts the phase to an 8-bit offset-binary sine sample through a
// 64-entry quarter-wave table, and drives a single-bit PWM whose duty follows
// the sample (intended for an RC reconstruction filter).
//
// Optional feature, macro SINE_AMPLITUDE_EN: adds an 8-bit amp input that
// scales the table magnitude ((mag*amp)>>8) in one extra registered stage.
// The default build (macro undefined) has no amp port and full-scale output.
module sine_sample_pwm #(
  parameter int PHASE_W = 8,   // >= 8
  parameter int STEP    = 1,   // < 2**(PHASE_W-1)
  parameter int PWM_W   = 8    // fixed at 8 in this revision
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       tick_in,
  input  logic       enable,
`ifdef SINE_AMPLITUDE_EN
  input  logic [7:0] amp,
`endif
  output logic [7:0] sample,
  output logic       sample_valid,
  output logic [1:0] quadrant,
  output logic       pwm_out
);

  localparam logic [PHASE_W-1:0] STEP_V = PHASE_W'(STEP);

  // First quarter of the wave: round(127*sin(2*pi*(i+0.5)/256)). The half
  // sample offset keeps the mirrored quarters symmetric without a duplicate
  // entry at the quadrant boundaries.
  localparam logic [6:0] SINE_LUT [64] = '{
    7'd2,   7'd5,   7'd8,   7'd11,  7'd14,  7'd17,  7'd20,  7'd23,
    7'd26,  7'd29,  7'd32,  7'd35,  7'd38,  7'd41,  7'd44,  7'd47,
    7'd50,  7'd53,  7'd56,  7'd58,  7'd61,  7'd64,  7'd67,  7'd69,
    7'd72,  7'd74,  7'd77,  7'd79,  7'd82,  7'd84,  7'd86,  7'd89,
    7'd91,  7'd93,  7'd95,  7'd97,  7'd99,  7'd101, 7'd103, 7'd105,
    7'd106, 7'd108, 7'd110, 7'd111, 7'd113, 7'd114, 7'd115, 7'd117,
    7'd118, 7'd119, 7'd120, 7'd121, 7'd122, 7'd123, 7'd124, 7'd124,
    7'd125, 7'd125, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127, 7'd127
  };

  // Tick synchroniser and edge detector
  logic s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic step;

  // Phase accumulator and pipeline
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               p1_vld_q, p1_vld_d;
  logic [7:0]         lut_p;
  logic [5:0]         lut_idx;
  logic [6:0]         mag_q, mag_d;
  logic [1:0]         mquad_q, mquad_d;
  logic               p2_vld_q, p2_vld_d;

`ifdef SINE_AMPLITUDE_EN
  logic [7:0]         amp_q, amp_d;
  logic [6:0]         mag_s_q, mag_s_d;
  logic [1:0]         squad_q, squad_d;
  logic               p3_vld_q, p3_vld_d;
`endif

  // Final magnitude stage feeding the output register
  logic [6:0]         out_mag;
  logic [1:0]         out_quad;
  logic               out_vld;

  // Output registers
  logic [7:0]         sample_q, sample_d;
  logic [1:0]         quadrant_q, quadrant_d;
  logic               sample_valid_q, sample_valid_d;

  // PWM
  logic [PWM_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         duty_q, duty_d;
  logic               pwm_q, pwm_d;

  // Tick edge detect, phase step, table lookup and sample formation
  always_comb begin
    // NOTE: every _d starts from a value on every path (hold = _q), so no
    // latch can be inferred.
    s1_d = tick_in;
    s2_d = s1_q;
    s3_d = s2_q;
    step = s2_q & ~s3_q & enable;

    phase_d  = step ? phase_q + STEP_V : phase_q;
    p1_vld_d = step;

    // Odd quadrants read the quarter table backwards (~idx == 63-idx).
    lut_p    = phase_q[PHASE_W-1 -: 8];
    lut_idx  = lut_p[6] ? ~lut_p[5:0] : lut_p[5:0];
    mag_d    = p1_vld_q ? SINE_LUT[lut_idx] : mag_q;
    mquad_d  = p1_vld_q ? lut_p[7:6] : mquad_q;
    p2_vld_d = p1_vld_q;

`ifdef SINE_AMPLITUDE_EN
    amp_d    = step ? amp : amp_q;
    mag_s_d  = p2_vld_q ? 7'(({8'd0, mag_q} * {7'd0, amp_q}) >> 8) : mag_s_q;
    squad_d  = p2_vld_q ? mquad_q : squad_q;
    p3_vld_d = p2_vld_q;
    out_mag  = mag_s_q;
    out_quad = squad_q;
    out_vld  = p3_vld_q;
`else
    out_mag  = mag_q;
    out_quad = mquad_q;
    out_vld  = p2_vld_q;
`endif

    // Positive half: 128+mag = {1,mag}. Negative half: 127-mag = {0,~mag}.
    sample_d       = out_vld ? {~out_quad[1], out_quad[1] ? ~out_mag : out_mag}
                             : sample_q;
    quadrant_d     = out_vld ? out_quad : quadrant_q;
    sample_valid_d = out_vld;
  end

  // Free-running PWM; duty reloads only at the wrap so a period is never split
  always_comb begin
    cnt_d  = cnt_q + PWM_W'(1);
    duty_d = (cnt_q == '1) ? sample_q : duty_q;
    pwm_d  = (cnt_q < duty_q);
  end

  // State registers, all cleared asynchronously by rst_n
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      s1_q           <= 1'b0;
      s2_q           <= 1'b0;
      s3_q           <= 1'b0;
      phase_q        <= '0;
      p1_vld_q       <= 1'b0;
      mag_q          <= '0;
      mquad_q        <= '0;
      p2_vld_q       <= 1'b0;
`ifdef SINE_AMPLITUDE_EN
      amp_q          <= '0;
      mag_s_q        <= '0;
      squad_q        <= '0;
      p3_vld_q       <= 1'b0;
`endif
      sample_q       <= 8'd128;
      quadrant_q     <= '0;
      sample_valid_q <= 1'b0;
      cnt_q          <= '0;
      duty_q         <= 8'd128;
      pwm_q          <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      s1_q           <= s1_d;
      s2_q           <= s2_d;
      s3_q           <= s3_d;
      phase_q        <= phase_d;
      p1_vld_q       <= p1_vld_d;
      mag_q          <= mag_d;
      mquad_q        <= mquad_d;
      p2_vld_q       <= p2_vld_d;
`ifdef SINE_AMPLITUDE_EN
      amp_q          <= amp_d;
      mag_s_q        <= mag_s_d;
      squad_q        <= squad_d;
      p3_vld_q       <= p3_vld_d;
`endif
      sample_q       <= sample_d;
      quadrant_q     <= quadrant_d;
      sample_valid_q <= sample_valid_d;
      cnt_q          <= cnt_d;
      duty_q         <= duty_d;
      pwm_q          <= pwm_d;
    end
  end

  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign quadrant     = quadrant_q;
  assign pwm_out      = pwm_q;

endmodule

// File: tb/tb_sine_sample_pwm.sv
// Self-checking bench for sine_sample_pwm. A behavioural model (real-valued
// sine, tick-to-output latency, cycle-count PWM) is compared with the DUT on
// every clock; directed literal checks pin the model at the test-plan points.
`timescale 1ns/1ps
module tb_sine_sample_pwm;

  localparam int PHASE_W = 8;
  localparam int STEP    = 1;
`ifdef SINE_AMPLITUDE_EN
  localparam int LAT     = 5;
  localparam int AMP_V   = 200;
  // Hand-computed with amp=200: (mag*200)>>8
  localparam int L_T1 = 131, L_Q1 = 227, L_Q2 = 126, L_Q3 = 28, L_Q0 = 129;
`else
  localparam int LAT     = 4;
  localparam int L_T1 = 133, L_Q1 = 255, L_Q2 = 125, L_Q3 = 0, L_Q0 = 130;
`endif

  logic       clk_in  = 1'b0;
  logic       rst_n   = 1'b0;
  logic       tick_in = 1'b0;
  logic       enable  = 1'b1;
`ifdef SINE_AMPLITUDE_EN
  logic [7:0] amp     = 8'(AMP_V);
`endif
  logic [7:0] sample;
  logic       sample_valid;
  logic [1:0] quadrant;
  logic       pwm_out;

  int checks = 0;
  int errors = 0;

  sine_sample_pwm #(.PHASE_W(PHASE_W), .STEP(STEP), .PWM_W(8)) dut (
    .clk_in       (clk_in),
    .rst_n        (rst_n),
    .tick_in      (tick_in),
    .enable       (enable),
`ifdef SINE_AMPLITUDE_EN
    .amp          (amp),
`endif
    .sample       (sample),
    .sample_valid (sample_valid),
    .quadrant     (quadrant),
    .pwm_out      (pwm_out)
  );

  initial forever #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Sample value straight from the sine definition and the quadrant rules
  function automatic int model_sample(input int ph);
    int  p, q, idx, mi, mag;
    real s;
    p   = (ph >> (PHASE_W - 8)) & 255;
    q   = p >> 6;
    idx = p & 63;
    mi  = (q == 1 || q == 3) ? 63 - idx : idx;
    s   = $sin(2.0 * 3.14159265358979 * (real'(mi) + 0.5) / 256.0);
    mag = $rtoi($floor(127.0 * s + 0.5));
`ifdef SINE_AMPLITUDE_EN
    mag = (mag * AMP_V) >> 8;
`endif
    return (q < 2) ? 128 + mag : 127 - mag;
  endfunction

  // Model state
  int cyc, m_phase, exp_sample, exp_quad, m_duty;
  bit prev_tick, exp_valid, exp_pwm;
  int due_q[$];
  int samp_q[$];
  int quad_q[$];
  int valid_cnt = 0;
  int period_high = 0;
  int last_period_high = -1;

  // Model update and per-cycle comparison
  initial begin
    forever begin
      @(posedge clk_in or negedge rst_n);
      if (!rst_n) begin
        cyc = 0; m_phase = 0; exp_sample = 128; exp_quad = 0; m_duty = 128;
        prev_tick = 1'b0; period_high = 0;
        due_q.delete(); samp_q.delete(); quad_q.delete();
      end else begin
        cyc++;
        if (tick_in && !prev_tick && enable) begin
          m_phase = (m_phase + STEP) % (1 << PHASE_W);
          due_q.push_back(cyc + LAT);
          samp_q.push_back(model_sample(m_phase));
          quad_q.push_back((m_phase >> (PHASE_W - 2)) & 3);
        end
        prev_tick = tick_in;
        exp_pwm = (((cyc - 1) % 256) < m_duty);
        if (((cyc - 1) % 256) == 255) m_duty = exp_sample;
        exp_valid = 1'b0;
        if (due_q.size() > 0 && due_q[0] == cyc) begin
          exp_valid  = 1'b1;
          exp_sample = samp_q.pop_front();
          exp_quad   = quad_q.pop_front();
          void'(due_q.pop_front());
        end
        #1;
        check("cyc_sample_valid", sample_valid, exp_valid);
        check("cyc_sample", sample, exp_sample);
        check("cyc_quadrant", quadrant, exp_quad);
        check("cyc_pwm_out", pwm_out, exp_pwm);
        if (sample_valid) valid_cnt++;
        if (pwm_out) period_high++;
        if (((cyc - 1) % 256) == 255) begin
          last_period_high = period_high;
          period_high = 0;
        end
      end
    end
  end

  // One tick: high 4 cycles, low 4 cycles; called at a falling clock edge
  task automatic do_tick();
    tick_in = 1'b1;
    repeat (4) @(negedge clk_in);
    tick_in = 1'b0;
    repeat (4) @(negedge clk_in);
  endtask

  int v0;

  initial begin
    // Reset held with tick toggling
    repeat (12) begin
      @(negedge clk_in);
      tick_in = ~tick_in;
    end
    check("rst_sample", sample, 128);
    check("rst_valid", sample_valid, 0);
    check("rst_quadrant", quadrant, 0);
    check("rst_pwm", pwm_out, 0);
    @(negedge clk_in);
    tick_in = 1'b0;
    repeat (3) @(negedge clk_in);
    rst_n = 1'b1;

    // Idle after release: outputs hold, PWM at midscale duty
    repeat (1000) @(negedge clk_in);
    check("idle_sample", sample, 128);
    check("idle_valid_pulses", valid_cnt, 0);
    check("duty128_highs", last_period_high, 128);

    // Single tick from phase 0
    v0 = valid_cnt;
    do_tick();
    check("tick1_sample", sample, L_T1);
    check("tick1_quadrant", quadrant, 0);
    check("tick1_pulses", valid_cnt - v0, 1);

    // Quadrant sweep
    repeat (63) do_tick();
    check("q1_sample", sample, L_Q1);
    check("q1_quadrant", quadrant, 1);
    repeat (512) @(negedge clk_in);
    check("duty_q1_highs", last_period_high, L_Q1);

    repeat (64) do_tick();
    check("q2_sample", sample, L_Q2);
    check("q2_quadrant", quadrant, 2);

    repeat (64) do_tick();
    check("q3_sample", sample, L_Q3);
    check("q3_quadrant", quadrant, 3);
    repeat (512) @(negedge clk_in);
    check("duty_q3_highs", last_period_high, L_Q3);

    repeat (64) do_tick();
    check("wrap_sample", sample, L_Q0);
    check("wrap_quadrant", quadrant, 0);
    check("sweep_pulses", valid_cnt - v0, 256);

    // Enable gating: ticks dropped, then exactly one step
    enable = 1'b0;
    v0 = valid_cnt;
    repeat (10) do_tick();
    check("gated_pulses", valid_cnt - v0, 0);
    check("gated_sample", sample, L_Q0);
    enable = 1'b1;
    do_tick();
    check("reenable_sample", sample, L_T1);
    check("reenable_pulses", valid_cnt - v0, 1);

    // Asynchronous reset mid-sweep, between clock edges
    repeat (5) do_tick();
    tick_in = 1'b1;
    repeat (3) @(posedge clk_in);
    #3 rst_n = 1'b0;
    #1;
    check("arst_sample", sample, 128);
    check("arst_valid", sample_valid, 0);
    check("arst_quadrant", quadrant, 0);
    check("arst_pwm", pwm_out, 0);
    @(negedge clk_in);
    tick_in = 1'b0;
    repeat (4) @(negedge clk_in);
    rst_n = 1'b1;
    @(negedge clk_in);
    do_tick();
    check("post_rst_sample", sample, L_T1);
    check("post_rst_quadrant", quadrant, 0);

    repeat (8) @(negedge clk_in);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
